// File: rtl/mudi_sched_if.sv
// Handshake/data bundle between the E-stage and the multiply/divide sequencer.
//   master : E-stage side, drives the command, operands and hazard inputs
//   slave  : mudi_sched side, returns busy, stall request, MF read data and HI/LO
interface mudi_sched_if;
  logic        start;      // MULT/MULTU/DIV/DIVU in E
  logic        we;         // MTHI/MTLO in E
  logic [2:0]  op;         // 0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MFHI,7 MFLO
  logic [31:0] A;          // rs operand
  logic [31:0] B;          // rt operand
  logic [31:0] Din;        // MTHI/MTLO data
  logic        exp_in;     // exception/flush, cancels the E-stage command
  logic        use_D;      // D-stage instr is mul/div-class
  logic        busy;       // operation in flight
  logic        stall_req;  // stall D-stage
  logic [31:0] Dout;       // MFHI/MFLO read data
  logic [31:0] hi;         // architectural HI
  logic [31:0] lo;         // architectural LO

  modport master (
    output start, we, op, A, B, Din, exp_in, use_D,
    input  busy, stall_req, Dout, hi, lo
  );

  modport slave (
    input  start, we, op, A, B, Din, exp_in, use_D,
    output busy, stall_req, Dout, hi, lo
  );
endinterface

// File: rtl/mudi_sched.sv
// Multiply/divide sequencer for the E stage. Owns HI/LO, computes the result at issue, holds it
// in pending registers for a fixed latency and commits it when the busy countdown expires.
// Ports:
//   Clk    : clock, rising edge
//   Reset  : synchronous, active-high
//   bus    : mudi_sched_if.slave (command, operands, hazard inputs; busy, stall_req, Dout, hi, lo)
module mudi_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic        Clk,
  input logic        Reset,
  mudi_sched_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic [31:0]       hi_q, lo_q;
  logic [31:0]       pend_hi_q, pend_lo_q;
  logic              pend_dz_q;

  logic              accept;
  logic              mt_wr;
  logic              is_signed;
  logic [63:0]       prod;
  logic [31:0]       mag_a, mag_b, mag_q, mag_r;
  logic [31:0]       quot, rem;
  logic [63:0]       res;

  // Only ops 0..3 start a timed operation; a flush in the same cycle cancels the command.
  assign accept = bus.start && !bus.exp_in && !bus.op[2] && (state_q == StIdle);
  assign mt_wr  = bus.we && !bus.exp_in && !busy_q && (bus.op[2:1] == 2'b10);

  // Result is computed at issue from the forwarded operands; operands need not be held.
  always_comb begin
    is_signed = !bus.op[0];
    // Low 64 bits of a 64x64 product of extended operands equal the 32x32 product.
    prod = is_signed ? ({{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B})
                     : ({32'b0, bus.A} * {32'b0, bus.B});
    // Signed divide via magnitudes; 0x80000000 negates to itself, which is its correct magnitude.
    mag_a = (is_signed && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
    mag_b = (is_signed && bus.B[31]) ? (32'd0 - bus.B) : bus.B;
    if (mag_b == 32'd0) begin
      mag_b = 32'd1;  // divide-by-zero result is discarded at commit
    end
    mag_q = mag_a / mag_b;
    mag_r = mag_a % mag_b;
    quot  = (is_signed && (bus.A[31] ^ bus.B[31])) ? (32'd0 - mag_q) : mag_q;
    rem   = (is_signed && bus.A[31]) ? (32'd0 - mag_r) : mag_r;
    res   = bus.op[1] ? {rem, quot} : prod;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            pend_hi_q <= res[63:32];
            pend_lo_q <= res[31:0];
            pend_dz_q <= bus.op[1] && (bus.B == 32'd0);
            cnt_q     <= bus.op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            busy_q    <= 1'b1;
            state_q   <= StRun;
          end else if (mt_wr) begin
            if (bus.op[0]) lo_q <= bus.Din;
            else           hi_q <= bus.Din;
          end
        end
        StRun: begin
          // New starts and MT writes are ignored while running.
          if (cnt_q == CntW'(1)) begin
            if (!pend_dz_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.stall_req = bus.use_D && (busy_q || (bus.start && !bus.exp_in));
  assign bus.Dout      = (bus.op == 3'd6) ? hi_q : (bus.op == 3'd7) ? lo_q : 32'b0;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mudi_sched.sv
module tb_mudi_sched;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   failures = 0;

  logic [63:0] sb_q[$];       // expected {hi,lo} per issued operation
  logic [31:0] m_hi, m_lo;    // bench model of architectural HI/LO

  mudi_sched_if bus ();

  mudi_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                        input logic [31:0] ch, cl);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      3'd2: begin
        if (b == 32'd0) return {ch, cl};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {ch, cl};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue one timed op, expecting {e_hi,e_lo} at commit.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b,
                        input logic [31:0] e_hi, e_lo, input string name);
    int          lat, cyc;
    logic [63:0] ev;
    lat = op[1] ? 10 : 5;
    sb_q.push_back({e_hi, e_lo});
    bus.op = op; bus.A = a; bus.B = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 50) begin
      cyc++;
      tick();
    end
    ev = sb_q.pop_front();
    checks++;
    if (cyc !== lat) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", name, cyc, lat);
    end
    checks++;
    if (bus.hi !== ev[63:32]) begin
      failures++;
      $display("FAIL %s hi got=%h exp=%h", name, bus.hi, ev[63:32]);
    end
    checks++;
    if (bus.lo !== ev[31:0]) begin
      failures++;
      $display("FAIL %s lo got=%h exp=%h", name, bus.lo, ev[31:0]);
    end
    m_hi = ev[63:32];
    m_lo = ev[31:0];
  endtask

  task automatic test_reset();
    bus.use_D = 1'b1;
    bus.op = 3'd6;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy busy=%b stall=%b exp=0/0", bus.busy, bus.stall_req);
    end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.Dout !== 32'h0) begin
      failures++;
      $display("FAIL reset_hilo hi=%h lo=%h dout=%h exp=0", bus.hi, bus.lo, bus.Dout);
    end
    bus.use_D = 1'b0;
    m_hi = 32'h0;
    m_lo = 32'h0;
  endtask

  task automatic test_mult();
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    bus.op = 3'd7;
    #1;
    checks++;
    if (bus.Dout !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL mflo got=%h exp=%h", bus.Dout, 32'hFFFF_FFFE);
    end
    bus.op = 3'd6;
    #1;
    checks++;
    if (bus.Dout !== 32'h0000_0001) begin
      failures++;
      $display("FAIL mfhi got=%h exp=%h", bus.Dout, 32'h1);
    end
    bus.op = 3'd4;
    #1;
    checks++;
    if (bus.Dout !== 32'h0) begin
      failures++;
      $display("FAIL dout_other got=%h exp=0", bus.Dout);
    end
  endtask

  task automatic test_div();
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(3'd2, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, "divu");
    run_op(3'd3, 32'd5, 32'd0, 32'h1, 32'h7FFF_FFFC, "divu_zero");
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, "div_posneg");
  endtask

  task automatic test_exp_in();
    bus.use_D = 1'b1;
    bus.op = 3'd0; bus.A = 32'd5; bus.B = 32'd5;
    bus.start = 1'b1; bus.exp_in = 1'b1;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL exp_stall got=%b exp=0", bus.stall_req);
    end
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      failures++;
      $display("FAIL exp_start busy=%b hi=%h lo=%h exp=0 %h %h", bus.busy, bus.hi, bus.lo,
               m_hi, m_lo);
    end
    bus.we = 1'b1; bus.op = 3'd4; bus.Din = 32'h1234;
    tick();
    bus.we = 1'b0; bus.exp_in = 1'b0; bus.use_D = 1'b0;
    checks++;
    if (bus.hi !== m_hi) begin
      failures++;
      $display("FAIL exp_mthi got=%h exp=%h", bus.hi, m_hi);
    end
  endtask

  task automatic test_mt();
    bus.we = 1'b1; bus.op = 3'd4; bus.Din = 32'h1234;
    tick();
    bus.op = 3'd5; bus.Din = 32'hABCD;
    checks++;
    if (bus.hi !== 32'h1234 || bus.lo !== m_lo) begin
      failures++;
      $display("FAIL mthi hi=%h lo=%h exp=%h %h", bus.hi, bus.lo, 32'h1234, m_lo);
    end
    tick();
    bus.we = 1'b0;
    checks++;
    if (bus.lo !== 32'hABCD || bus.hi !== 32'h1234) begin
      failures++;
      $display("FAIL mtlo hi=%h lo=%h exp=%h %h", bus.hi, bus.lo, 32'h1234, 32'hABCD);
    end
    m_hi = 32'h1234;
    m_lo = 32'hABCD;
  endtask

  task automatic test_stall();
    bus.use_D = 1'b1;
    bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd4; bus.start = 1'b1;
    #1;
    checks++;
    if (bus.stall_req !== 1'b1) begin
      failures++;
      $display("FAIL stall_issue got=%b exp=1", bus.stall_req);
    end
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.stall_req !== 1'b1) begin
        failures++;
        $display("FAIL stall_busy cyc=%0d busy=%b stall=%b exp=1/1", i, bus.busy,
                 bus.stall_req);
      end
      if (i == 1) begin
        bus.we = 1'b1; bus.op = 3'd5; bus.Din = 32'hDEAD;
      end else begin
        bus.we = 1'b0;
      end
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL stall_drop busy=%b stall=%b exp=0/0", bus.busy, bus.stall_req);
    end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd12) begin
      failures++;
      $display("FAIL stall_result hi=%h lo=%h exp=0 c", bus.hi, bus.lo);
    end
    m_hi = 32'h0;
    m_lo = 32'd12;
    bus.use_D = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_busy got=%b exp=1", bus.busy);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid busy=%b hi=%h lo=%h exp=0", bus.busy, bus.hi, bus.lo);
    end
    repeat (12) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      failures++;
      $display("FAIL rst_late_commit busy=%b hi=%h lo=%h exp=0", bus.busy, bus.hi, bus.lo);
    end
    m_hi = 32'h0;
    m_lo = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] ev;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i == 5) begin
        op = 3'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
      ev = model(op, a, b, m_hi, m_lo);
      run_op(op, a, b, ev[63:32], ev[31:0], $sformatf("b2b%0d_op%0d", i, op));
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.start = 1'b0; bus.we = 1'b0; bus.op = 3'd0;
    bus.A = '0; bus.B = '0; bus.Din = '0;
    bus.exp_in = 1'b0; bus.use_D = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_exp_in();
    test_mt();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
